// File: rtl/row_word_sender.sv
// row_word_sender: latches a compressed row, publishes its decompression header, streams it MSB-first as words
// Ports: clk/rst (async active-low); row_in/row_bits/row_valid/row_ready row intake;
// send/stop chip pacing; data/data_valid word stream; startDecompression, rowSize, extraBits,
// initialRowSize, splitSize header; row_count/image_done image bookkeeping.
module row_word_sender #(
  parameter int ROW_W = 480,
  parameter int WORD_W = 16,
  parameter int ROWS_PER_IMAGE = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row_in,
  input  logic [15:0]       row_bits,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic              send,
  input  logic              stop,
  output logic [WORD_W-1:0] data,
  output logic              data_valid,
  output logic              startDecompression,
  output logic [15:0]       rowSize,
  output logic [15:0]       extraBits,
  output logic [15:0]       initialRowSize,
  output logic [15:0]       splitSize,
  output logic [7:0]        row_count,
  output logic              image_done
);
  typedef enum logic [1:0] {IDLE, START, STREAM, ROW_END} state_t;
  state_t state_q;
  logic [ROW_W-1:0] sh_q;
  logic [WORD_W-1:0] data_q, top, word_d;
  logic [15:0] size_q, extra_q, init_q, split_q, idx_q, idx_d, size_d, split_d, extra_d;
  logic [7:0] cnt_q;
  logic dv_q, sd_q, done_q;
  // sh_q is pre-shifted so its top word is always the next word to publish; idx_d is that word's index
  always_comb begin
    size_d = row_bits > 16'(ROW_W) ? 16'(ROW_W) : row_bits;
    split_d = 16'((32'(size_d) + WORD_W - 1) / WORD_W);
    extra_d = 16'((WORD_W - 32'(size_d) % WORD_W) % WORD_W);
    top = sh_q[ROW_W-1 -: WORD_W];
    idx_d = idx_q + 16'(state_q == STREAM);
    word_d = idx_d == split_q - 16'd1 ? top & ({WORD_W{1'b1}} << extra_q) : top;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      data_q <= '0;
      size_q <= '0;
      extra_q <= '0;
      init_q <= '0;
      split_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      dv_q <= 1'b0;
      sd_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sd_q <= 1'b0;
      case (state_q)
        IDLE: if (row_valid) begin
          sh_q <= row_in;
          size_q <= size_d;
          split_q <= split_d;
          extra_q <= extra_d;
          idx_q <= '0;
          done_q <= 1'b0;
          sd_q <= 1'b1;
          if (cnt_q == 8'd0) init_q <= size_d;
          state_q <= START;
        end
        START: if (split_q == 16'd0) state_q <= ROW_END;
        else begin
          data_q <= word_d;
          dv_q <= 1'b1;
          sh_q <= sh_q << WORD_W;
          state_q <= STREAM;
        end
        STREAM: if (!stop && send) begin
          if (idx_q == split_q - 16'd1) begin
            dv_q <= 1'b0;
            state_q <= ROW_END;
          end else begin
            data_q <= word_d;
            sh_q <= sh_q << WORD_W;
            idx_q <= idx_d;
          end
        end
        ROW_END: begin
          cnt_q <= cnt_q == 8'(ROWS_PER_IMAGE - 1) ? 8'd0 : cnt_q + 8'd1;
          if (cnt_q == 8'(ROWS_PER_IMAGE - 1)) done_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign row_ready = state_q == IDLE;
  assign data = data_q;
  assign data_valid = dv_q;
  assign startDecompression = sd_q;
  assign rowSize = size_q;
  assign extraBits = extra_q;
  assign initialRowSize = init_q;
  assign splitSize = split_q;
  assign row_count = cnt_q;
  assign image_done = done_q;
endmodule

// File: tb/tb_row_word_sender.sv
// tb_row_word_sender: scoreboard bench for row_word_sender against an arithmetic row/word model
module tb_row_word_sender;
  localparam int ROW_W = 480;
  localparam int W = 16;
  localparam int RPI = 30;
  logic clk = 1'b0, rst = 1'b0;
  logic [ROW_W-1:0] row_in = '0;
  logic [15:0] row_bits = '0;
  logic row_valid = 1'b0, send = 1'b0, stop = 1'b0;
  logic row_ready, data_valid, startDecompression, image_done;
  logic [W-1:0] data;
  logic [15:0] rowSize, extraBits, initialRowSize, splitSize;
  logic [7:0] row_count;
  typedef struct {int size; int split; int extra; int init;} hdr_t;
  hdr_t hq[$];
  logic [15:0] wq[$];
  int errors = 0, checks = 0;
  int m_cnt = 0, m_init = 0;
  bit m_done = 0;
  row_word_sender #(.ROW_W(ROW_W), .WORD_W(W), .ROWS_PER_IMAGE(RPI)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .row_bits(row_bits), .row_valid(row_valid),
    .row_ready(row_ready), .send(send), .stop(stop), .data(data), .data_valid(data_valid),
    .startDecompression(startDecompression), .rowSize(rowSize), .extraBits(extraBits),
    .initialRowSize(initialRowSize), .splitSize(splitSize), .row_count(row_count),
    .image_done(image_done)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] model_word(logic [ROW_W-1:0] r, int k, int split, int extra);
    logic [ROW_W-1:0] s;
    logic [15:0] w;
    s = r >> (ROW_W - W * (k + 1));
    w = s[15:0];
    if (k == split - 1) w = w & ~((16'h1 << extra) - 16'h1);
    return w;
  endfunction
  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (startDecompression) begin
        if (hq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_start: got 1 expected 0");
        end else begin
          chk("rowSize", rowSize, hq[0].size);
          chk("splitSize", splitSize, hq[0].split);
          chk("extraBits", extraBits, hq[0].extra);
          chk("initialRowSize", initialRowSize, hq[0].init);
          void'(hq.pop_front());
        end
      end
      if (data_valid) begin
        if (wq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_word: got 0x%0h expected none", data);
        end else begin
          chk("data_word", data, wq[0]);
          if (send && !stop) void'(wq.pop_front());
        end
      end
    end
  end
  task automatic check_reset_outputs();
    chk("rst_row_ready", row_ready, 1);
    chk("rst_data", data, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_start", startDecompression, 0);
    chk("rst_rowSize", rowSize, 0);
    chk("rst_extraBits", extraBits, 0);
    chk("rst_initialRowSize", initialRowSize, 0);
    chk("rst_splitSize", splitSize, 0);
    chk("rst_row_count", row_count, 0);
    chk("rst_image_done", image_done, 0);
  endtask
  task automatic issue(logic [ROW_W-1:0] r, int bits, output int split);
    int size, extra;
    size = bits > ROW_W ? ROW_W : bits;
    split = (size + W - 1) / W;
    extra = (W - size % W) % W;
    if (m_cnt == 0) m_init = size;
    hq.push_back('{size, split, extra, m_init});
    for (int k = 0; k < split; k++) wq.push_back(model_word(r, k, split, extra));
    chk("ready_before_accept", row_ready, 1);
    row_in = r;
    row_bits = 16'(bits);
    row_valid = 1'b1;
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    m_done = 0;
    chk("ready_after_accept", row_ready, 0);
    chk("image_done_cleared", image_done, 0);
  endtask
  // mode 1: send held; 2: random send/stop with ignored row offers; 3: 5-cycle stop on word 3; 4: reset at word 10
  task automatic run_row(logic [ROW_W-1:0] r, int bits, int mode);
    int split, k, cyc, stop_left;
    bit fired;
    k = 0; cyc = 0; stop_left = 5; fired = 0;
    issue(r, bits, split);
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (fired) k++;
      if (row_ready) break;
      if (cyc > 3000) begin
        errors++; checks++;
        $display("FAIL row_timeout: got %0d words expected %0d", k, split);
        break;
      end
      if (mode == 4 && k == 10 && data_valid) begin
        #1 rst = 1'b0;
        #1;
        check_reset_outputs();
        wq.delete();
        hq.delete();
        m_cnt = 0;
        m_done = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      if (mode == 2) begin
        send = 1'($urandom_range(0, 1));
        stop = $urandom_range(0, 3) == 0;
        row_valid = data_valid && k < split - 1 && $urandom_range(0, 1) == 1;
        row_in = rnd_row();
        row_bits = 16'($urandom_range(0, 700));
      end else if (mode == 3 && k == 3 && data_valid && stop_left > 0) begin
        send = 1'b1;
        stop = 1'b1;
        stop_left--;
      end else begin
        send = 1'b1;
        stop = 1'b0;
      end
      fired = data_valid && send && !stop;
    end
    row_valid = 1'b0;
    chk("words_sent", k, split);
    if (mode == 3) chk("stop_cycles_used", stop_left, 0);
    m_cnt++;
    if (m_cnt == RPI) begin
      m_cnt = 0;
      m_done = 1;
    end
    chk("row_count", row_count, m_cnt);
    chk("image_done", image_done, int'(m_done));
    chk("words_drained", wq.size(), 0);
    chk("headers_drained", hq.size(), 0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [ROW_W-1:0] ones;
    ones = '1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_row(ones, 480, 1);
    run_row(ones, 20, 1);
    run_row(rnd_row(), 480, 3);
    run_row(rnd_row(), 0, 1);
    run_row(rnd_row(), 600, 2);
    run_row(rnd_row(), 480, 4);
    for (int i = 0; i < RPI; i++) run_row(rnd_row(), 100, 2);
    run_row(rnd_row(), 64, 2);
    for (int i = 0; i < 8; i++) run_row(rnd_row(), $urandom_range(0, 700), 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/row_word_sender.md
Name: row_word_sender

Overview:
- CPU-side transmitter for the compressed-image row interface; it is the sending end of the 16-bit word stream that the chip's decompression front end consumes.
- Latches one wide compressed row plus its valid-bit count and publishes the decompression header: startDecompression, rowSize, extraBits, initialRowSize, splitSize.
- Serialises the row MSB-first into 16-bit words, paced by the chip's send/stop handshake.
- Counts rows per image and flags image completion.

Parameters:
- ROW_W, 480, width of one compressed row in bits; must be a multiple of WORD_W.
- WORD_W, 16, width of the data bus word.
- ROWS_PER_IMAGE, 30, rows per image before image_done asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- row_in  in  ROW_W  compressed row; valid bits are left-justified from bit ROW_W-1.
- row_bits  in  16  number of valid bits in row_in.
- row_valid  in  1  row_in/row_bits are offered; accepted when row_valid and row_ready are both high at a clk edge.
- row_ready  out  1  block is idle and can accept a row.
- send  in  1  chip request for the next word (level, sampled each clk).
- stop  in  1  chip back-pressure; freezes streaming.
- data  out  WORD_W  current word.
- data_valid  out  1  data holds a valid word.
- startDecompression  out  1  one-cycle pulse; header outputs are valid.
- rowSize  out  16  clamped valid-bit count of the current row.
- extraBits  out  16  zero-pad bits in the last word.
- initialRowSize  out  16  rowSize of the first row of the current image.
- splitSize  out  16  number of words in the current row.
- row_count  out  8  rows fully sent in the current image.
- image_done  out  1  high after ROWS_PER_IMAGE rows until the next accepted row.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; row_ready=1.
  - data, rowSize, extraBits, initialRowSize, splitSize, row_count = 0.
  - data_valid, startDecompression, image_done = 0.
  - Reset mid-row discards the row; no partial-state recovery.
- Width rules:
  - rowSize = min(row_bits, ROW_W).
  - splitSize = ceil(rowSize/WORD_W).
  - extraBits = (WORD_W - rowSize mod WORD_W) mod WORD_W.
  - rowSize=0 gives splitSize=0 and extraBits=0.
- Word k = row_in[ROW_W-1-k*WORD_W -: WORD_W], for k = 0..splitSize-1. In the last word, the low extraBits bits are forced to 0 regardless of row_in.
- IDLE:
  - row_ready=1.
  - On accept: latch the row and header fields, clear image_done. If row_count==0, also latch initialRowSize. Go to START.
- START (1 cycle):
  - startDecompression=1 and row_ready=0.
  - If splitSize=0, go to ROW_END; otherwise load word 0 into data, set data_valid=1, go to STREAM.
- STREAM, evaluated at each clk edge:
  - stop=1: hold data, data_valid and the word index. stop has priority over send.
  - stop=0, send=1, not the last word: advance to the next word on the next cycle. Each send-high cycle advances exactly one word; a held send streams one word per cycle.
  - stop=0, send=1, last word: data_valid=0, go to ROW_END.
  - send=0: hold.
- ROW_END (1 cycle):
  - row_count increments.
  - If row_count reaches ROWS_PER_IMAGE: image_done=1 and row_count=0.
  - Go to IDLE.
- Timing and counters:
  - Latency from row accept to startDecompression is 1 cycle; word 0 is valid the cycle after startDecompression.
  - row_valid outside IDLE is ignored; the row is not queued.
  - row_count wraps only through the ROWS_PER_IMAGE rule.
  - initialRowSize is held across all rows of an image.

Test Plan:
- Reset then row_bits=480, row_in=all-ones, send held high -> startDecompression pulses once; splitSize=30, extraBits=0; data=16'hFFFF for exactly 30 consecutive data_valid cycles; row_count=1.
- row_bits=20, row_in top 20 bits=1, rest=1 -> splitSize=2, extraBits=12; words are 16'hFFFF then 16'hF000.
- Streaming with stop=1 for 5 cycles after word 3 while send=1 -> word 3 is held on data for all 5 cycles; word 4 appears only after stop falls; no words are skipped or duplicated.
- 30 rows of row_bits=100, then a row of row_bits=64 -> image_done=1 after row 30 and clears on the next accept. initialRowSize=100 throughout the first image and becomes 64 for the next image.
- row_bits=0 and row_bits=600 -> 0: startDecompression pulses, data_valid stays 0, row_count increments. 600: rowSize=480, splitSize=30.
- rst pulled low during word 10 of a row -> all outputs return to their reset values asynchronously; a new row is accepted immediately after rst returns high.
